// File: rtl/divmod_share_ctrl_pkg.sv
// Shared types and constants for the controller that time-shares one divider
// between the CPU execute stage (requester 0) and the helper unit (requester 1).
package divmod_share_ctrl_pkg;

  localparam int DIV_SHARE_NUM_REQ = 2;
  localparam int DIV_SHARE_W       = 64;
  localparam int DIV_SHARE_OP32_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_share_state_e;

  typedef struct packed {
    logic                   sgn;
    logic                   is64;
    logic [DIV_SHARE_W-1:0] num;
    logic [DIV_SHARE_W-1:0] denom;
  } div_share_req_t;

  typedef struct packed {
    logic [DIV_SHARE_W-1:0] quot;
    logic [DIV_SHARE_W-1:0] rem;
    logic                   dbz;
  } div_share_rsp_t;

  function automatic logic [DIV_SHARE_NUM_REQ-1:0] req_onehot(input logic id);
    logic [DIV_SHARE_NUM_REQ-1:0] vec_s;
    if (id) vec_s = 2'b10;
    else    vec_s = 2'b01;
    return vec_s;
  endfunction

endpackage

// File: rtl/divmod_share_ctrl_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that was not served last wins.
module divmod_share_ctrl_rr_pick
  import divmod_share_ctrl_pkg::*;
(
  input  logic [DIV_SHARE_NUM_REQ-1:0] valid,
  input  logic                         last_grant,
  output logic                         grant,
  output logic                         any
);

  // Grant selection.
  always_comb begin
    grant = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    any = |valid;
  end

endmodule

// File: rtl/divmod_share_ctrl.sv
// Arbitrates two requesters onto one shared divider, prepares 32/64-bit
// operands, short-circuits divide-by-zero and returns results per requester.
module divmod_share_ctrl
  import divmod_share_ctrl_pkg::*;
#(
  parameter int DIV_W  = DIV_SHARE_W,
  parameter int OP32_W = DIV_SHARE_OP32_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [DIV_SHARE_NUM_REQ-1:0]            req_valid,
  output logic [DIV_SHARE_NUM_REQ-1:0]            req_ready,
  input  logic [DIV_SHARE_NUM_REQ-1:0]            req_sgn,
  input  logic [DIV_SHARE_NUM_REQ-1:0]            req_is64,
  input  logic [DIV_SHARE_NUM_REQ-1:0][DIV_W-1:0] req_num,
  input  logic [DIV_SHARE_NUM_REQ-1:0][DIV_W-1:0] req_denom,
  output logic [DIV_SHARE_NUM_REQ-1:0]            rsp_valid,
  input  logic [DIV_SHARE_NUM_REQ-1:0]            rsp_ready,
  output logic [DIV_W-1:0]                        rsp_quot,
  output logic [DIV_W-1:0]                        rsp_rem,
  output logic                                    rsp_dbz,
  output logic                                    div_enable,
  output logic                                    div_unsgn_or_sgn,
  output logic [DIV_W-1:0]                        div_num,
  output logic [DIV_W-1:0]                        div_denom,
  input  logic [DIV_W-1:0]                        div_quot,
  input  logic [DIV_W-1:0]                        div_rem,
  input  logic                                    div_can_accept_cmd,
  input  logic                                    div_data_ready
);

  localparam int EXT_W = DIV_W - OP32_W;

  function automatic logic [DIV_W-1:0] extend_operand(input logic [DIV_W-1:0] raw,
                                                      input logic is64, input logic sgn);
    logic [DIV_W-1:0] ext_s;
    if (is64)     ext_s = raw;
    else if (sgn) ext_s = {{EXT_W{raw[OP32_W-1]}}, raw[OP32_W-1:0]};
    else          ext_s = {{EXT_W{1'b0}}, raw[OP32_W-1:0]};
    return ext_s;
  endfunction

  function automatic logic [DIV_W-1:0] fit_result(input logic [DIV_W-1:0] raw, input logic is64);
    logic [DIV_W-1:0] fit_s;
    if (is64) fit_s = raw;
    else      fit_s = {{EXT_W{1'b0}}, raw[OP32_W-1:0]};
    return fit_s;
  endfunction

  div_share_state_e state_r, state_nxt_s;
  div_share_req_t   op_r;
  div_share_rsp_t   rsp_r;
  logic             last_grant_r;
  logic             id_r;
  logic             grant_s;
  logic             any_s;
  logic             accept_s;
  logic             sel_sgn_s;
  logic             sel_is64_s;
  logic             dbz_s;
  logic [DIV_W-1:0] sel_num_s;
  logic [DIV_W-1:0] sel_denom_s;
  logic [DIV_W-1:0] ext_num_s;
  logic [DIV_W-1:0] ext_denom_s;
  logic [DIV_W-1:0] dbz_quot_s;

  divmod_share_ctrl_rr_pick u_rr_pick (
    .valid      (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .any        (any_s)
  );

  // Operand preparation for the currently granted requester.
  always_comb begin
    sel_sgn_s   = req_sgn[grant_s];
    sel_is64_s  = req_is64[grant_s];
    sel_num_s   = req_num[grant_s];
    sel_denom_s = req_denom[grant_s];
    ext_num_s   = extend_operand(sel_num_s, sel_is64_s, sel_sgn_s);
    ext_denom_s = extend_operand(sel_denom_s, sel_is64_s, sel_sgn_s);
    dbz_s       = (ext_denom_s == {DIV_W{1'b0}});
    dbz_quot_s  = sel_is64_s ? {DIV_W{1'b1}} : {{EXT_W{1'b0}}, {OP32_W{1'b1}}};
    accept_s    = rst_n && (state_r == IDLE) && any_s && req_valid[grant_s];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    div_enable  = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s && rst_n) req_ready[grant_s] = 1'b1;
        if (accept_s) state_nxt_s = dbz_s ? RESP : ISSUE;
        else          state_nxt_s = IDLE;
      end
      ISSUE: begin
        if (div_can_accept_cmd) begin
          div_enable  = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        if (div_data_ready) state_nxt_s = RESP;
        else                state_nxt_s = WAIT;
      end
      RESP: begin
        rsp_valid = req_onehot(id_r);
        if (rsp_ready[id_r]) state_nxt_s = IDLE;
        else                 state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Command latch, result capture and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r         <= '0;
      rsp_r        <= '0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r       <= grant_s;
            op_r.sgn   <= sel_sgn_s;
            op_r.is64  <= sel_is64_s;
            op_r.num   <= ext_num_s;
            op_r.denom <= ext_denom_s;
            // Zero divisor never reaches the divider; the answer is fixed here.
            if (dbz_s) begin
              rsp_r.quot <= dbz_quot_s;
              rsp_r.rem  <= fit_result(sel_num_s, sel_is64_s);
              rsp_r.dbz  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (div_data_ready) begin
            rsp_r.quot <= fit_result(div_quot, op_r.is64);
            rsp_r.rem  <= fit_result(div_rem, op_r.is64);
            rsp_r.dbz  <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready[id_r]) last_grant_r <= id_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_unsgn_or_sgn = op_r.sgn;
  assign div_num          = op_r.num;
  assign div_denom        = op_r.denom;
  assign rsp_quot         = rsp_r.quot;
  assign rsp_rem          = rsp_r.rem;
  assign rsp_dbz          = rsp_r.dbz;

endmodule

// File: tb/tb_divmod_share_ctrl.sv
// Directed bench for divmod_share_ctrl with a 5-cycle behavioural divider.
module tb_divmod_share_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_sgn, req_is64;
  logic [1:0][63:0]  req_num, req_denom;
  logic [1:0]        rsp_valid, rsp_ready;
  logic [63:0]       rsp_quot, rsp_rem;
  logic              rsp_dbz;
  logic              div_enable, div_unsgn_or_sgn;
  logic [63:0]       div_num, div_denom;
  logic [63:0]       div_quot = 64'd0;
  logic [63:0]       div_rem = 64'd0;
  logic              div_can_accept_cmd;
  logic              div_data_ready = 1'b0;
  logic              can_accept_en;

  logic              mdl_busy = 1'b0;
  int                mdl_cnt = 0;
  logic [63:0]       mdl_q = 64'd0;
  logic [63:0]       mdl_r = 64'd0;

  int                checks = 0;
  int                errors = 0;

  logic [1:0]        obs_rdy, obs_vld;
  logic [63:0]       obs_dnum, obs_dden, obs_q, obs_rm;
  logic              obs_dsgn, obs_en0, obs_dz, obs_got;
  int                obs_gap, obs_en_extra, obs_busy_rdy;

  always #5 clk = ~clk;

  divmod_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sgn(req_sgn), .req_is64(req_is64),
    .req_num(req_num), .req_denom(req_denom),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
    .rsp_dbz(rsp_dbz),
    .div_enable(div_enable), .div_unsgn_or_sgn(div_unsgn_or_sgn),
    .div_num(div_num), .div_denom(div_denom), .div_quot(div_quot), .div_rem(div_rem),
    .div_can_accept_cmd(div_can_accept_cmd), .div_data_ready(div_data_ready)
  );

  // Behavioural divider: not reset by rst_n, result 5 cycles after the command.
  assign div_can_accept_cmd = ~mdl_busy & can_accept_en;

  always @(posedge clk) begin
    div_data_ready <= 1'b0;
    if (mdl_busy) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        div_data_ready <= 1'b1;
        div_quot       <= mdl_q;
        div_rem        <= mdl_r;
        mdl_busy       <= 1'b0;
      end
    end else if (div_enable && div_can_accept_cmd) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 5;
      if (div_unsgn_or_sgn) begin
        mdl_q <= $signed(div_num) / $signed(div_denom);
        mdl_r <= $signed(div_num) % $signed(div_denom);
      end else begin
        mdl_q <= div_num / div_denom;
        mdl_r <= div_num % div_denom;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  task automatic set_req(input logic r, input logic sgn, input logic is64,
                         input logic [63:0] num, input logic [63:0] den);
    req_sgn[r]   = sgn;
    req_is64[r]  = is64;
    req_num[r]   = num;
    req_denom[r] = den;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Waits (bounded) for rsp_valid; records enable pulses, ready leaks and data_ready->rsp gap.
  task automatic wait_rsp();
    int dr_at;
    dr_at = -100; obs_got = 1'b0; obs_gap = -1; obs_en_extra = 0; obs_busy_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00) begin
        obs_got = 1'b1; obs_gap = i - dr_at;
        break;
      end
      if (div_enable) obs_en_extra++;
      if (div_data_ready) dr_at = i;
      if (req_ready != 2'b00) obs_busy_rdy++;
    end
  endtask

  // Drives one non-zero-divisor command through to its response handshake.
  task automatic run_op(input logic r, input logic sgn, input logic is64,
                        input logic [63:0] num, input logic [63:0] den);
    set_req(r, sgn, is64, num, den);
    #1; obs_rdy = req_ready;
    @(negedge clk); req_valid[r] = 1'b0; #1;
    obs_en0 = div_enable; obs_dnum = div_num; obs_dden = div_denom; obs_dsgn = div_unsgn_or_sgn;
    wait_rsp();
    obs_vld = rsp_valid; obs_q = rsp_quot; obs_rm = rsp_rem; obs_dz = rsp_dbz;
    rsp_ready[r] = 1'b1;
    @(negedge clk); rsp_ready[r] = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (div_enable !== 1'b0) begin errors++; $display("FAIL reset_div_enable: got %b want 0", div_enable); end
    checks++; if ({div_num, div_denom, div_unsgn_or_sgn} !== 129'd0) begin errors++; $display("FAIL reset_div_bus: num %h denom %h sgn %b want 0", div_num, div_denom, div_unsgn_or_sgn); end
    checks++; if ({rsp_quot, rsp_rem, rsp_dbz} !== 129'd0) begin errors++; $display("FAIL reset_rsp_bus: quot %h rem %h dbz %b want 0", rsp_quot, rsp_rem, rsp_dbz); end
    req_valid = 2'b00; rst_n = 1'b1;
  endtask

  task automatic test_basic_64();
    run_op(1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    checks++; if (obs_rdy !== 2'b01) begin errors++; $display("FAIL basic_ready: got %b want 01", obs_rdy); end
    checks++; if (obs_en0 !== 1'b1) begin errors++; $display("FAIL basic_enable_latency: got %b want 1", obs_en0); end
    checks++; if (obs_dnum !== 64'd100 || obs_dden !== 64'd7 || obs_dsgn !== 1'b0) begin errors++; $display("FAIL basic_div_bus: num %h denom %h sgn %b want 64/7/0", obs_dnum, obs_dden, obs_dsgn); end
    checks++; if (obs_en_extra !== 0) begin errors++; $display("FAIL basic_single_enable: got %0d extra pulses want 0", obs_en_extra); end
    checks++; if (obs_got !== 1'b1 || obs_gap !== 1) begin errors++; $display("FAIL basic_rsp_latency: got %b gap %0d want 1 gap 1", obs_got, obs_gap); end
    checks++; if (obs_vld !== 2'b01) begin errors++; $display("FAIL basic_rsp_valid: got %b want 01", obs_vld); end
    checks++; if (obs_q !== 64'd14 || obs_rm !== 64'd2 || obs_dz !== 1'b0) begin errors++; $display("FAIL basic_result: quot %h rem %h dbz %b want 14/2/0", obs_q, obs_rm, obs_dz); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL basic_rsp_drop: got %b want 00", rsp_valid); end
  endtask

  task automatic test_32bit();
    run_op(1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_FFFF_FFF9, 64'h5555_AAAA_0000_0002);
    checks++; if (obs_rdy !== 2'b10) begin errors++; $display("FAIL s32_ready: got %b want 10", obs_rdy); end
    checks++; if (obs_dnum !== 64'hFFFF_FFFF_FFFF_FFF9 || obs_dden !== 64'd2 || obs_dsgn !== 1'b1) begin errors++; $display("FAIL s32_div_bus: num %h denom %h sgn %b", obs_dnum, obs_dden, obs_dsgn); end
    checks++; if (obs_vld !== 2'b10) begin errors++; $display("FAIL s32_rsp_valid: got %b want 10", obs_vld); end
    checks++; if (obs_q !== 64'h0000_0000_FFFF_FFFD || obs_rm !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL s32_result: quot %h rem %h", obs_q, obs_rm); end
    run_op(1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    checks++; if (obs_dnum !== 64'hFFFF_FFFF_8000_0000 || obs_dden !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL s32_min_div_bus: num %h denom %h", obs_dnum, obs_dden); end
    checks++; if (obs_q !== 64'h0000_0000_8000_0000 || obs_rm !== 64'd0) begin errors++; $display("FAIL s32_min_result: quot %h rem %h want 80000000/0", obs_q, obs_rm); end
    run_op(1'b0, 1'b0, 1'b0, 64'h1234_0000_FFFF_FFF9, 64'h0000_0001_0000_0002);
    checks++; if (obs_dnum !== 64'h0000_0000_FFFF_FFF9 || obs_dden !== 64'd2 || obs_dsgn !== 1'b0) begin errors++; $display("FAIL u32_div_bus: num %h denom %h sgn %b", obs_dnum, obs_dden, obs_dsgn); end
    checks++; if (obs_q !== 64'h0000_0000_7FFF_FFFC || obs_rm !== 64'd1) begin errors++; $display("FAIL u32_result: quot %h rem %h want 7ffffffc/1", obs_q, obs_rm); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(1'b0, 1'b0, 1'b1, 64'd50, 64'd5);
    set_req(1'b1, 1'b0, 1'b1, 64'd9, 64'd4);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b want 01", req_ready); end
    @(negedge clk); req_valid[0] = 1'b0; #1;
    checks++; if (div_num !== 64'd50) begin errors++; $display("FAIL rr_first_operand: got %h want 32", div_num); end
    wait_rsp();
    checks++; if (obs_got !== 1'b1 || rsp_valid !== 2'b01) begin errors++; $display("FAIL rr_first_owner: got %b want 01", rsp_valid); end
    checks++; if (rsp_quot !== 64'd10 || rsp_rem !== 64'd0) begin errors++; $display("FAIL rr_first_result: quot %h rem %h want 10/0", rsp_quot, rsp_rem); end
    checks++; if (obs_busy_rdy !== 0 || req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_while_busy: %0d cycles, now %b want 0/00", obs_busy_rdy, req_ready); end
    rsp_ready = 2'b01; req_valid[0] = 1'b1;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b want 10", req_ready); end
    @(negedge clk); req_valid[1] = 1'b0; #1;
    checks++; if (div_num !== 64'd9) begin errors++; $display("FAIL rr_second_operand: got %h want 9", div_num); end
    wait_rsp();
    checks++; if (obs_got !== 1'b1 || rsp_valid !== 2'b10) begin errors++; $display("FAIL rr_second_owner: got %b want 10", rsp_valid); end
    checks++; if (rsp_quot !== 64'd2 || rsp_rem !== 64'd1 || obs_busy_rdy !== 0) begin errors++; $display("FAIL rr_second_result: quot %h rem %h leaks %0d", rsp_quot, rsp_rem, obs_busy_rdy); end
    rsp_ready = 2'b10; req_valid[1] = 1'b1;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_third_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_dbz();
    int en_cnt;
    en_cnt = 0;
    set_req(1'b0, 1'b0, 1'b0, 64'hAAAA_0000_0000_1234, 64'hFFFF_FFFF_0000_0000);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL dbz_ready: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (rsp_valid !== 2'b01 || div_enable !== 1'b0) begin errors++; $display("FAIL dbz_latency: valid %b enable %b want 01/0", rsp_valid, div_enable); end
    checks++; if (rsp_quot !== 64'h0000_0000_FFFF_FFFF || rsp_rem !== 64'h1234 || rsp_dbz !== 1'b1) begin errors++; $display("FAIL dbz32_result: quot %h rem %h dbz %b", rsp_quot, rsp_rem, rsp_dbz); end
    repeat (3) begin
      @(negedge clk); #1;
      if (div_enable) en_cnt++;
    end
    checks++; if (en_cnt !== 0 || rsp_valid !== 2'b01) begin errors++; $display("FAIL dbz_no_enable: pulses %0d valid %b want 0/01", en_cnt, rsp_valid); end
    rsp_ready = 2'b01; @(negedge clk); rsp_ready = 2'b00; #1;
    set_req(1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0001, 64'd0);
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_quot !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_rem !== 64'h8000_0000_0000_0001 || rsp_dbz !== 1'b1) begin errors++; $display("FAIL dbz64_result: valid %b quot %h rem %h dbz %b", rsp_valid, rsp_quot, rsp_rem, rsp_dbz); end
    rsp_ready = 2'b01; @(negedge clk); rsp_ready = 2'b00; #1;
  endtask

  task automatic test_stall();
    int en_cnt;
    int bad;
    en_cnt = 0; bad = 0;
    can_accept_en = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    @(negedge clk); req_valid = 2'b00; #1;
    if (div_enable) en_cnt++;
    repeat (2) begin
      @(negedge clk); #1;
      if (div_enable) en_cnt++;
    end
    checks++; if (en_cnt !== 0) begin errors++; $display("FAIL stall_no_enable: got %0d pulses want 0", en_cnt); end
    @(negedge clk); can_accept_en = 1'b1; #1;
    checks++; if (div_enable !== 1'b1) begin errors++; $display("FAIL stall_enable_on_accept: got %b want 1", div_enable); end
    wait_rsp();
    checks++; if (obs_got !== 1'b1 || obs_en_extra !== 0 || rsp_valid !== 2'b10) begin errors++; $display("FAIL stall_rsp: valid %b extra pulses %0d", rsp_valid, obs_en_extra); end
    repeat (4) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b10 || rsp_quot !== 64'hFFFF_FFFF_FFFF_FFF2 ||
          rsp_rem !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_dbz !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_rsp_stable: %0d unstable cycles, quot %h rem %h", bad, rsp_quot, rsp_rem); end
    rsp_ready = 2'b10; @(negedge clk); rsp_ready = 2'b00; #1;
  endtask

  task automatic test_reset_mid_op();
    int stale;
    int bad;
    stale = 0; bad = 0;
    set_req(1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || div_enable !== 1'b0) begin errors++; $display("FAIL midrst_handshake: ready %b valid %b enable %b want 0", req_ready, rsp_valid, div_enable); end
    checks++; if ({div_num, div_denom, rsp_quot, rsp_rem, rsp_dbz} !== 257'd0) begin errors++; $display("FAIL midrst_buses: num %h quot %h rem %h want 0", div_num, rsp_quot, rsp_rem); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (div_data_ready) stale++;
      if (rsp_valid !== 2'b00 || div_enable !== 1'b0) bad++;
    end
    checks++; if (stale !== 1 || bad !== 0) begin errors++; $display("FAIL midrst_stale_ignored: stale %0d bad %0d want 1/0", stale, bad); end
    run_op(1'b1, 1'b0, 1'b1, 64'd81, 64'd9);
    checks++; if (obs_rdy !== 2'b10 || obs_en0 !== 1'b1) begin errors++; $display("FAIL midrst_next_accept: ready %b enable %b want 10/1", obs_rdy, obs_en0); end
    checks++; if (obs_vld !== 2'b10 || obs_q !== 64'd9 || obs_rm !== 64'd0) begin errors++; $display("FAIL midrst_next_result: valid %b quot %h rem %h", obs_vld, obs_q, obs_rm); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; req_sgn = 2'b00; req_is64 = 2'b00;
    req_num = '0; req_denom = '0; can_accept_en = 1'b1;
    test_reset();
    test_basic_64();
    test_32bit();
    test_round_robin();
    test_dbz();
    test_stall();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
